// File: rtl/gprf_dump_ctrl.sv
// Debug read-out engine: walks a GPRF register range through one read port and streams
// each word out over valid/ready. Optional trailing XOR checksum beat under DUMP_CHECKSUM_EN.
module gprf_dump_ctrl #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   output logic [ADDR_W-1:0] rf_address,
   input  logic [DATA_W-1:0] rf_data,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [DATA_W-1:0] dump_data,
   output logic [ADDR_W-1:0] dump_addr,
   output logic              dump_last,
   output logic              busy,
   output logic              done,
   output logic [2:0]        dbg_state
);

   // Handshake: a beat transfers on a rising edge where dump_valid && dump_ready; while
   // dump_valid is high and dump_ready low, dump_data/dump_addr/dump_last hold; ready alone is ignored.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_SEND = 3'd2,
`ifdef DUMP_CHECKSUM_EN
      S_CSUM = 3'd3,
`endif
      S_DONE = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cur_q, cur_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] cur_inc;
   logic              at_last;
`ifdef DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q, csum_d;
`endif

   assign cur_inc = (cur_q == ADDR_W'(NUM_REGS - 1)) ? '0 : cur_q + 1'b1;
   assign at_last = (cur_q == last_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cur_q   <= '0;
         last_q  <= '0;
         data_q  <= '0;
         addr_q  <= '0;
`ifdef DUMP_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         last_q  <= last_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
`ifdef DUMP_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      last_d  = last_q;
      data_d  = data_q;
      addr_d  = addr_q;
`ifdef DUMP_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cur_d   = first_addr;
               last_d  = last_addr;
`ifdef DUMP_CHECKSUM_EN
               csum_d  = '0;
`endif
               state_d = S_READ;
            end
         end
         S_READ: begin
            data_d  = rf_data;
            addr_d  = cur_q;
            state_d = S_SEND;
         end
         S_SEND: begin
            if (dump_ready) begin
`ifdef DUMP_CHECKSUM_EN
               csum_d = csum_q ^ data_q;
`endif
               if (at_last) begin
`ifdef DUMP_CHECKSUM_EN
                  // The checksum beat reuses the output registers so it holds like any beat.
                  data_d  = csum_q ^ data_q;
                  addr_d  = '0;
                  state_d = S_CSUM;
`else
                  state_d = S_DONE;
`endif
               end else begin
                  cur_d   = cur_inc;
                  state_d = S_READ;
               end
            end
         end
`ifdef DUMP_CHECKSUM_EN
         S_CSUM: begin
            if (dump_ready) state_d = S_DONE;
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign rf_address = (state_q == S_READ) ? cur_q : '0;
   assign dump_data  = data_q;
   assign dump_addr  = addr_q;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign dbg_state  = state_q;
`ifdef DUMP_CHECKSUM_EN
   assign dump_valid = (state_q == S_SEND) || (state_q == S_CSUM);
   assign dump_last  = (state_q == S_CSUM);
`else
   assign dump_valid = (state_q == S_SEND);
   assign dump_last  = (state_q == S_SEND) && at_last;
`endif

endmodule

// File: tb/tb_gprf_dump_ctrl.sv
// Bench for gprf_dump_ctrl: GPRF array model, range-level expected-beat queue, per-cycle
// compare process and directed range/stall/reset scenarios.
module tb_gprf_dump_ctrl;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int EW = 1 + AW + DW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] first_addr = '0;
   logic [AW-1:0] last_addr = '0;
   logic [AW-1:0] rf_address;
   logic [DW-1:0] rf_data;
   logic          dump_valid;
   logic          dump_ready = 1'b0;
   logic [DW-1:0] dump_data;
   logic [AW-1:0] dump_addr;
   logic          dump_last;
   logic          busy;
   logic          done;
   logic [2:0]    dbg_state;

   logic [DW-1:0] rf_mem [32];
   assign rf_data = rf_mem[rf_address];

   gprf_dump_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .first_addr(first_addr), .last_addr(last_addr),
      .rf_address(rf_address), .rf_data(rf_data), .dump_valid(dump_valid),
      .dump_ready(dump_ready), .dump_data(dump_data), .dump_addr(dump_addr),
      .dump_last(dump_last), .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   logic [EW-1:0] exp_q[$];
   logic [AW-1:0] acc_addr[$];
   logic [DW-1:0] acc_data[$];
   logic          acc_last[$];
   bit            pend_done = 0;
   bit            pend_idle = 0;
   bit            prev_stall = 0;
   logic [EW-1:0] prev_beat;
   logic [EW-1:0] cur_beat;
   logic [EW-1:0] e_beat;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Expected beats derived from the range rule: count = ((last-first) mod 32)+1, wrapping.
   task automatic model_dump(input logic [AW-1:0] f, input logic [AW-1:0] l);
      int            cnt;
      logic [AW-1:0] a;
      logic [AW-1:0] diff;
      logic [DW-1:0] x;
      logic          lst;
      diff = l - f;
      cnt  = int'(diff) + 1;
      x    = '0;
      for (int i = 0; i < cnt; i++) begin
         a   = f + AW'(i);
         lst = (i == cnt - 1);
`ifdef DUMP_CHECKSUM_EN
         lst = 1'b0;
`endif
         exp_q.push_back({lst, a, rf_mem[a]});
         x = x ^ rf_mem[a];
      end
`ifdef DUMP_CHECKSUM_EN
      exp_q.push_back({1'b1, 5'd0, x});
`endif
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         pend_done  = 0;
         pend_idle  = 0;
         prev_stall = 0;
      end else begin
         cur_beat = {dump_last, dump_addr, dump_data};
         if (pend_idle) begin
            chk("busy_after_done", 64'(busy), 64'd0);
            pend_idle = 0;
         end
         if (pend_done) begin
            chk("done_pulse", 64'(done), 64'd1);
            chk("busy_in_done", 64'(busy), 64'd1);
            pend_done = 0;
            pend_idle = 1;
         end else begin
            chk("done_quiet", 64'(done), 64'd0);
         end
         if (prev_stall) begin
            chk("stall_valid_held", 64'(dump_valid), 64'd1);
            chk("stall_beat_stable", 64'(cur_beat), 64'(prev_beat));
         end
         if (dump_valid) begin
            chk("busy_with_valid", 64'(busy), 64'd1);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_beat: got %0h want none", cur_beat);
            end else begin
               e_beat = exp_q[0];
               chk("beat_data", 64'(dump_data), 64'(e_beat[DW-1:0]));
               chk("beat_addr", 64'(dump_addr), 64'(e_beat[DW+AW-1:DW]));
               chk("beat_last", 64'(dump_last), 64'(e_beat[EW-1]));
               if (dump_ready) begin
                  void'(exp_q.pop_front());
                  acc_addr.push_back(dump_addr);
                  acc_data.push_back(dump_data);
                  acc_last.push_back(dump_last);
                  if (exp_q.size() == 0) pend_done = 1;
               end
            end
         end
         prev_stall = dump_valid && !dump_ready;
         prev_beat  = cur_beat;
      end
   end

   task automatic do_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
      model_dump(f, l);
      acc_addr.delete();
      acc_data.delete();
      acc_last.delete();
      @(posedge clk); #1;
      start = 1'b1;
      first_addr = f;
      last_addr = l;
      @(posedge clk); #1;
      start = 1'b0;
      first_addr = ~f;
      last_addr = ~l;
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("valid_after_1_edge", 64'(dump_valid), 64'd0);
      @(posedge clk); #1;
      chk("valid_after_2_edges", 64'(dump_valid), 64'd1);
   endtask

   task automatic wait_done();
      int k = 0;
      while ((exp_q.size() != 0 || pend_done || pend_idle) && k < 2000) begin
         @(posedge clk);
         k++;
      end
      #1;
      if (k >= 2000) begin
         n_cmp++;
         n_fail++;
         $display("FAIL dump_timeout: got %0d beats left want 0", exp_q.size());
      end
      chk("model_drained", 64'(exp_q.size()), 64'd0);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      int  k;
      bit  stalled;
      for (int i = 0; i < 32; i++) rf_mem[i] = i * 32'h01010101;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(dump_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_rf_address", 64'(rf_address), 64'd0);
      chk("rst_data", 64'(dump_data), 64'd0);
      chk("rst_last", 64'(dump_last), 64'd0);
      chk("rst_state", 64'(dbg_state), 64'd0);
      rst = 1'b1;
      dump_ready = 1'b1;

      // 1: full dump, ready held high
      do_start(5'd0, 5'd31);
      wait_done();
`ifdef DUMP_CHECKSUM_EN
      chk("t1_count", 64'(acc_addr.size()), 64'd33);
      chk("t1_csum_data", 64'(acc_data[32]), 64'd0);
      chk("t1_last31", 64'(acc_last[31]), 64'd0);
`else
      chk("t1_count", 64'(acc_addr.size()), 64'd32);
      chk("t1_last31", 64'(acc_last[31]), 64'd1);
`endif
      chk("t1_reg0", 64'(acc_data[0]), 64'd0);
      chk("t1_data31", 64'(acc_data[31]), 64'h1F1F1F1F);
      chk("t1_addr31", 64'(acc_addr[31]), 64'd31);
      chk("t1_last30", 64'(acc_last[30]), 64'd0);

      // 2: full dump with a 3-cycle stall on addr 5
      do_start(5'd0, 5'd31);
      stalled = 0;
      k = 0;
      while (exp_q.size() != 0 && k < 2000) begin
         @(posedge clk); #1;
         k++;
         if (!stalled && dump_valid && dump_addr == 5'd5) begin
            dump_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            dump_ready = 1'b1;
            stalled = 1;
         end
      end
      wait_done();
      chk("t2_stalled", 64'(stalled), 64'd1);
      chk("t2_addr5", 64'(acc_addr[5]), 64'd5);
      chk("t2_addr6", 64'(acc_addr[6]), 64'd6);
      chk("t2_data5", 64'(acc_data[5]), 64'h05050505);

      // 3: wrapping range
      do_start(5'd30, 5'd1);
      wait_done();
      chk("t3_a0", 64'(acc_addr[0]), 64'd30);
      chk("t3_a1", 64'(acc_addr[1]), 64'd31);
      chk("t3_a2", 64'(acc_addr[2]), 64'd0);
      chk("t3_a3", 64'(acc_addr[3]), 64'd1);
      chk("t3_last2", 64'(acc_last[2]), 64'd0);
`ifndef DUMP_CHECKSUM_EN
      chk("t3_last3", 64'(acc_last[3]), 64'd1);
`endif

      // 4: single-register range
      do_start(5'd7, 5'd7);
      wait_done();
      chk("t4_data", 64'(acc_data[0]), 64'h07070707);
      chk("t4_addr", 64'(acc_addr[0]), 64'd7);
`ifdef DUMP_CHECKSUM_EN
      chk("t4_count", 64'(acc_addr.size()), 64'd2);
`else
      chk("t4_count", 64'(acc_addr.size()), 64'd1);
      chk("t4_last", 64'(acc_last[0]), 64'd1);
`endif

      // 5a: start while busy is ignored
      do_start(5'd10, 5'd12);
      @(posedge clk); #1;
      start = 1'b1;
      first_addr = 5'd20;
      last_addr = 5'd25;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();
      chk("t5_addr_end", 64'(acc_addr[2]), 64'd12);
      chk("t5_data_mid", 64'(acc_data[1]), 64'h0B0B0B0B);

      // 5b: reset while beat 3 is on the bus
      do_start(5'd0, 5'd31);
      k = 0;
      while (acc_addr.size() < 2 && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      k = 0;
      while (!dump_valid && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      @(negedge clk); #2;
      rst = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_valid", 64'(dump_valid), 64'd0);
      chk("mid_rst_data", 64'(dump_data), 64'd0);
      chk("mid_rst_addr", 64'(dump_addr), 64'd0);
      chk("mid_rst_last", 64'(dump_last), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      chk("mid_rst_rf_address", 64'(rf_address), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      do_start(5'd4, 5'd6);
      wait_done();
      chk("t5_restart_a0", 64'(acc_addr[0]), 64'd4);
      chk("t5_restart_d2", 64'(acc_data[2]), 64'h06060606);

      // 6: checksum pattern
      rf_mem[1] = 32'h000000F0;
      rf_mem[2] = 32'h0000000F;
      rf_mem[3] = 32'h000000FF;
      do_start(5'd1, 5'd3);
      wait_done();
      chk("t6_addr2", 64'(acc_addr[2]), 64'd3);
`ifdef DUMP_CHECKSUM_EN
      chk("t6_count", 64'(acc_addr.size()), 64'd4);
      chk("t6_csum_data", 64'(acc_data[3]), 64'd0);
      chk("t6_csum_addr", 64'(acc_addr[3]), 64'd0);
      chk("t6_csum_last", 64'(acc_last[3]), 64'd1);
      chk("t6_last2", 64'(acc_last[2]), 64'd0);
`else
      chk("t6_count", 64'(acc_addr.size()), 64'd3);
      chk("t6_last2", 64'(acc_last[2]), 64'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
